// File: rtl/mcs4_seq_pkg.sv
// MCS-4 bus sequencer shared types: subcycle and bus-owner enums,
// plus the per-subcycle owner lookup used by the grant logic.
package mcs4_seq_pkg;

  localparam int NUM_SUBCYCLES = 8;

  typedef enum logic [2:0] {
    SC_A1 = 3'd0,
    SC_A2 = 3'd1,
    SC_A3 = 3'd2,
    SC_M1 = 3'd3,
    SC_M2 = 3'd4,
    SC_X1 = 3'd5,
    SC_X2 = 3'd6,
    SC_X3 = 3'd7
  } subcycle_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_ROM,
    OWN_EXT
  } owner_e;

  function automatic subcycle_e sc_next(input subcycle_e sc);
    return subcycle_e'(sc + 3'd1);
  endfunction

  // rd/wr are the latched, conflict-filtered X2 controls.
  function automatic owner_e owner_of(
    input subcycle_e sc,
    input logic      rd,
    input logic      wr,
    input logic      src
  );
    owner_e o;
    o = OWN_NONE;
    case (sc)
      SC_A1, SC_A2, SC_A3: o = OWN_CPU;
      SC_M1, SC_M2:        o = OWN_ROM;
      SC_X2: o = rd ? OWN_EXT : (wr ? OWN_CPU : OWN_NONE);
      SC_X3: o = src ? OWN_CPU : OWN_NONE;
      default: o = OWN_NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mcs4_bus_sequencer_if.sv
// Sequencer bus bundle: instruction controls in, clocks, subcycle
// strobes, bus grants and status out. master = sequencer side.
// cycle_cnt exists only with MCS4_SEQ_CYCLE_CNT_EN defined.
interface mcs4_bus_sequencer_if;

  logic halt_req;
  logic io_rd;
  logic io_wr;
  logic src_x3;
  logic clk1;
  logic clk2;
  logic a1, a2, a3, m1, m2, x1, x2, x3;
  logic sync;
  logic grant_cpu;
  logic grant_rom;
  logic grant_ext;
  logic halted;
  logic bus_conflict;
`ifdef MCS4_SEQ_CYCLE_CNT_EN
  logic [15:0] cycle_cnt;

  modport master (
    input  halt_req, io_rd, io_wr, src_x3,
    output clk1, clk2,
    output a1, a2, a3, m1, m2, x1, x2, x3,
    output sync, grant_cpu, grant_rom, grant_ext,
    output halted, bus_conflict, cycle_cnt
  );

  modport slave (
    output halt_req, io_rd, io_wr, src_x3,
    input  clk1, clk2,
    input  a1, a2, a3, m1, m2, x1, x2, x3,
    input  sync, grant_cpu, grant_rom, grant_ext,
    input  halted, bus_conflict, cycle_cnt
  );
`else
  modport master (
    input  halt_req, io_rd, io_wr, src_x3,
    output clk1, clk2,
    output a1, a2, a3, m1, m2, x1, x2, x3,
    output sync, grant_cpu, grant_rom, grant_ext,
    output halted, bus_conflict
  );

  modport slave (
    output halt_req, io_rd, io_wr, src_x3,
    input  clk1, clk2,
    input  a1, a2, a3, m1, m2, x1, x2, x3,
    input  sync, grant_cpu, grant_rom, grant_ext,
    input  halted, bus_conflict
  );
`endif

endinterface

// File: rtl/mcs4_phase_clkgen.sv
// Quarter counter and two-phase clock generator (QLEN sysclk per quarter).
// Ports: clk_i, rst_ni, hold_i in; clk1_o, clk2_o, sc_end_o, sc_adv_o, q_nxt_o out.
module mcs4_phase_clkgen #(
  parameter int QLEN = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       hold_i,
  output logic       clk1_o,
  output logic       clk2_o,
  output logic       sc_end_o,
  output logic       sc_adv_o,
  output logic [1:0] q_nxt_o
);

  localparam logic [3:0] QMAX = 4'(QLEN - 1);

  logic       run_q;
  logic [1:0] q_q, q_d;
  logic [3:0] cnt_q, cnt_d;
  logic       clk1_q, clk2_q;
  logic       last;
  logic       adv;

  // State is the position shown on the outputs; the first edge after
  // reset only starts the outputs without advancing.
  assign last     = (cnt_q == QMAX);
  assign sc_end_o = run_q && (q_q == 2'd3) && last;

  always_comb begin
    adv      = run_q && !hold_i;
    sc_adv_o = adv && sc_end_o;
    q_d      = q_q;
    cnt_d    = cnt_q;
    if (adv) begin
      if (last) begin
        cnt_d = 4'd0;
        q_d   = q_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
    q_nxt_o = q_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q  <= 1'b0;
      q_q    <= 2'd0;
      cnt_q  <= 4'd0;
      clk1_q <= 1'b0;
      clk2_q <= 1'b0;
    end else begin
      run_q  <= 1'b1;
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      clk1_q <= !hold_i && (q_d == 2'd0);
      clk2_q <= !hold_i && (q_d == 2'd2);
    end
  end

  assign clk1_o = clk1_q;
  assign clk2_o = clk2_q;

endmodule

// File: rtl/mcs4_bus_sequencer.sv
// MCS-4 data-bus master sequencer: subcycle FSM, bus grants, halt.
// Ports: sysclk, poc_n; bus (mcs4_bus_sequencer_if.master). Option: MCS4_SEQ_CYCLE_CNT_EN.
module mcs4_bus_sequencer
  import mcs4_seq_pkg::*;
#(
  parameter int QLEN = 2
) (
  input logic                  sysclk,
  input logic                  poc_n,
  mcs4_bus_sequencer_if.master bus
);

  subcycle_e sc_q, sc_d;
  logic      halted_q;
  logic      rd_q, wr_q, src_q;
  logic      gc_q, gr_q, ge_q;
  logic      conf_q;
  logic [NUM_SUBCYCLES-1:0] ind_q;

  logic       clk1, clk2;
  logic       sc_end, sc_adv;
  logic [1:0] q_nxt;
  logic       halt_go, hold;
  logic       x1_entry;
  logic       keep;
  owner_e     own_cur, own_nxt;

  mcs4_phase_clkgen #(
    .QLEN(QLEN)
  ) u_clkgen (
    .clk_i    (sysclk),
    .rst_ni   (poc_n),
    .hold_i   (hold),
    .clk1_o   (clk1),
    .clk2_o   (clk2),
    .sc_end_o (sc_end),
    .sc_adv_o (sc_adv),
    .q_nxt_o  (q_nxt)
  );

  assign halt_go = sc_end && !halted_q
                && (sc_q == SC_X3) && bus.halt_req;
  assign hold    = halt_go || (halted_q && bus.halt_req);

  always_comb begin
    sc_d     = sc_adv ? sc_next(sc_q) : sc_q;
    x1_entry = sc_adv && (sc_q == SC_M2);
    own_cur  = owner_of(sc_d, rd_q, wr_q, src_q);
    own_nxt  = owner_of(sc_next(sc_d), rd_q, wr_q, src_q);
    // q3 is turnaround unless the next subcycle keeps the owner.
    keep     = !hold && ((q_nxt != 2'd3) || (own_cur == own_nxt));
  end

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      sc_q     <= SC_A1;
      halted_q <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      src_q    <= 1'b0;
      conf_q   <= 1'b0;
      ind_q    <= '0;
      gc_q     <= 1'b0;
      gr_q     <= 1'b0;
      ge_q     <= 1'b0;
    end else begin
      sc_q <= sc_d;
      if (halt_go) begin
        halted_q <= 1'b1;
      end else if (halted_q && !bus.halt_req) begin
        halted_q <= 1'b0;
      end
      // A read/write clash cancels both directions.
      if (x1_entry) begin
        rd_q  <= bus.io_rd && !bus.io_wr;
        wr_q  <= bus.io_wr && !bus.io_rd;
        src_q <= bus.src_x3;
      end
      conf_q <= x1_entry && bus.io_rd && bus.io_wr;
      ind_q  <= 8'd1 << sc_d;
      gc_q   <= keep && (own_cur == OWN_CPU);
      gr_q   <= keep && (own_cur == OWN_ROM);
      ge_q   <= keep && (own_cur == OWN_EXT);
    end
  end

`ifdef MCS4_SEQ_CYCLE_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      cnt_q <= 16'd0;
    end else if (sc_adv && (sc_q == SC_X3)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.cycle_cnt = cnt_q;
`endif

  assign bus.clk1         = clk1;
  assign bus.clk2         = clk2;
  assign bus.a1           = ind_q[0];
  assign bus.a2           = ind_q[1];
  assign bus.a3           = ind_q[2];
  assign bus.m1           = ind_q[3];
  assign bus.m2           = ind_q[4];
  assign bus.x1           = ind_q[5];
  assign bus.x2           = ind_q[6];
  assign bus.x3           = ind_q[7];
  assign bus.sync         = ind_q[7];
  assign bus.grant_cpu    = gc_q;
  assign bus.grant_rom    = gr_q;
  assign bus.grant_ext    = ge_q;
  assign bus.halted       = halted_q;
  assign bus.bus_conflict = conf_q;

endmodule

// File: tb/tb_mcs4_bus_sequencer.sv
// Testbench for mcs4_bus_sequencer: random and directed stimulus
// against a position-counting reference model of the instruction cycle.
module tb_mcs4_bus_sequencer;

  localparam int QLEN = 2;
  localparam int SUB  = 4 * QLEN;
  localparam int CYC  = 8 * SUB;

  logic sysclk = 1'b0;
  logic poc_n  = 1'b0;

  always #5 sysclk = ~sysclk;

  mcs4_bus_sequencer_if bus();

  mcs4_bus_sequencer #(
    .QLEN(QLEN)
  ) dut (
    .sysclk (sysclk),
    .poc_n  (poc_n),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: p = sysclk index within the instruction cycle.
  bit          m_started, m_halted;
  bit          m_rd, m_wr, m_src, m_conf;
  int          m_p;
  logic [15:0] m_cnt;

  task automatic model_reset();
    m_started = 0; m_halted = 0;
    m_rd = 0; m_wr = 0; m_src = 0; m_conf = 0;
    m_p = 0; m_cnt = 16'd0;
  endtask

  task automatic model_edge();
    m_conf = 0;
    if (!m_started) begin
      m_started = 1;
      m_p = 0;
    end else if (m_halted) begin
      if (!bus.halt_req) begin
        m_halted = 0; m_p = 0; m_cnt = m_cnt + 16'd1;
      end
    end else if (m_p == CYC - 1) begin
      if (bus.halt_req) m_halted = 1;
      else begin
        m_p = 0; m_cnt = m_cnt + 16'd1;
      end
    end else begin
      m_p = m_p + 1;
      if (m_p == 5 * SUB) begin
        m_conf = bus.io_rd && bus.io_wr;
        m_rd   = bus.io_rd && !bus.io_wr;
        m_wr   = bus.io_wr && !bus.io_rd;
        m_src  = bus.src_x3;
      end
    end
  endtask

  // 0 none, 1 cpu, 2 rom, 3 ext
  function automatic int own(int sc);
    if (sc <= 2) return 1;
    if (sc <= 4) return 2;
    if (sc == 5) return 0;
    if (sc == 6) return m_rd ? 3 : (m_wr ? 1 : 0);
    return m_src ? 1 : 0;
  endfunction

  function automatic logic [15:0] exp_vec();
    int sc, qi, o;
    logic [7:0] ind;
    if (!m_started) return 16'h0;
    sc = m_p / SUB;
    qi = (m_p % SUB) / QLEN;
    o  = own(sc);
    if (m_halted || (qi == 3 && o != own((sc + 1) % 8))) o = 0;
    ind = 8'h0;
    ind[sc] = 1'b1;
    return {!m_halted && qi == 0, !m_halted && qi == 2, ind,
            sc == 7, o == 1, o == 2, o == 3, m_halted, m_conf};
  endfunction

  function automatic logic [15:0] obs();
    return {bus.clk1, bus.clk2,
            bus.x3, bus.x2, bus.x1, bus.m2,
            bus.m1, bus.a3, bus.a2, bus.a1,
            bus.sync, bus.grant_cpu, bus.grant_rom, bus.grant_ext,
            bus.halted, bus.bus_conflict};
  endfunction

  task automatic tick();
    @(posedge sysclk);
    model_edge();
    #1;
  endtask

  task automatic rand_io();
    bus.io_rd  = 1'($urandom_range(0, 1));
    bus.io_wr  = 1'($urandom_range(0, 1));
    bus.src_x3 = 1'($urandom_range(0, 1));
  endtask

  task automatic advance_to(int target);
    int i;
    bus.halt_req = 1'b0;
    i = 0;
    while (!(m_p == target && !m_halted && m_started) && i < 3 * CYC) begin
      tick();
      rand_io();
      i++;
    end
    n_chk++;
    if (i >= 3 * CYC) begin
      n_fail++;
      $display("FAIL advance_to: p=%0d required %0d", m_p, target);
    end
  endtask

  task automatic test_reset();
    bus.halt_req = 0; bus.io_rd = 0; bus.io_wr = 0; bus.src_x3 = 0;
    model_reset();
    repeat (2) @(posedge sysclk);
    #1;
    n_chk++;
    if (obs() !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0", obs());
    end
`ifdef MCS4_SEQ_CYCLE_CNT_EN
    n_chk++;
    if (bus.cycle_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %h required 0", bus.cycle_cnt);
    end
`endif
    poc_n = 1'b1;
    tick();
    n_chk++;
    if (obs() !== exp_vec() || bus.a1 !== 1'b1 || bus.clk1 !== 1'b1) begin
      n_fail++;
      $display("FAIL first_edge: got %b required %b", obs(), exp_vec());
    end
  endtask

  task automatic test_free_run();
    int c1, s;
    c1 = 0; s = 0;
    for (int i = 0; i < 2 * CYC; i++) begin
      rand_io();
      tick();
      c1 += int'(bus.clk1);
      s  += int'(bus.sync);
      n_chk++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL free_run p=%0d: got %b required %b", m_p, obs(), exp_vec());
      end
    end
    n_chk++;
    if (c1 != 2 * 8 * QLEN || s != 2 * SUB) begin
      n_fail++;
      $display("FAIL free_run_counts: clk1=%0d sync=%0d required %0d %0d",
               c1, s, 2 * 8 * QLEN, 2 * SUB);
    end
  endtask

  task automatic test_io_read();
    int ge;
    ge = 0;
    advance_to(5 * SUB - 1);
    bus.io_rd = 1; bus.io_wr = 0; bus.src_x3 = 0;
    tick();
    bus.io_rd = 0;
    for (int i = 0; i < 3 * SUB; i++) begin
      tick();
      if (bus.x2) ge += int'(bus.grant_ext);
      n_chk++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL io_read p=%0d: got %b required %b", m_p, obs(), exp_vec());
      end
    end
    n_chk++;
    if (ge != 3 * QLEN || bus.a1 !== 1'b1 || bus.grant_cpu !== 1'b1) begin
      n_fail++;
      $display("FAIL io_read_ext: ext=%0d a1=%b cpu=%b required %0d 1 1",
               ge, bus.a1, bus.grant_cpu, 3 * QLEN);
    end
  endtask

  task automatic test_conflict();
    int pulses, g;
    pulses = 0; g = 0;
    advance_to(5 * SUB - 1);
    bus.io_rd = 1; bus.io_wr = 1;
    bus.src_x3 = 1'($urandom_range(0, 1));
    for (int i = 0; i < CYC; i++) begin
      tick();
      rand_io();
      pulses += int'(bus.bus_conflict);
      if (bus.x2) g += int'(bus.grant_cpu | bus.grant_ext | bus.grant_rom);
      n_chk++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL conflict p=%0d: got %b required %b", m_p, obs(), exp_vec());
      end
    end
    n_chk++;
    if (pulses != 1 || g != 0) begin
      n_fail++;
      $display("FAIL conflict_pulse: pulses=%0d x2grants=%0d required 1 0", pulses, g);
    end
  endtask

  task automatic test_halt();
    logic [15:0] c0;
    advance_to(CYC - 1);
    c0 = m_cnt;
    bus.halt_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      rand_io();
      n_chk++;
      if (obs() !== exp_vec() || bus.halted !== 1'b1 || bus.x3 !== 1'b1) begin
        n_fail++;
        $display("FAIL halt_hold: got %b required %b", obs(), exp_vec());
      end
`ifdef MCS4_SEQ_CYCLE_CNT_EN
      n_chk++;
      if (bus.cycle_cnt !== c0) begin
        n_fail++;
        $display("FAIL halt_cnt: got %h required %h", bus.cycle_cnt, c0);
      end
`endif
    end
    bus.halt_req = 1'b0;
    tick();
    n_chk++;
    if (obs() !== exp_vec() || bus.a1 !== 1'b1 ||
        bus.clk1 !== 1'b1 || bus.halted !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_resume: got %b required %b", obs(), exp_vec());
    end
`ifdef MCS4_SEQ_CYCLE_CNT_EN
    n_chk++;
    if (bus.cycle_cnt !== c0 + 16'd1) begin
      n_fail++;
      $display("FAIL resume_cnt: got %h required %h", bus.cycle_cnt, c0 + 16'd1);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 6 * CYC; i++) begin
      rand_io();
      bus.halt_req = ($urandom_range(0, 3) == 0);
      tick();
      n_chk++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random p=%0d h=%0d: got %b required %b",
                 m_p, m_halted, obs(), exp_vec());
      end
`ifdef MCS4_SEQ_CYCLE_CNT_EN
      n_chk++;
      if (bus.cycle_cnt !== m_cnt) begin
        n_fail++;
        $display("FAIL random_cnt: got %h required %h", bus.cycle_cnt, m_cnt);
      end
`endif
    end
    bus.halt_req = 1'b0;
  endtask

  task automatic test_poc_mid();
    advance_to(4 * SUB + QLEN);
    n_chk++;
    if (bus.grant_rom !== 1'b1 || bus.m2 !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_poc: rom=%b m2=%b required 1 1", bus.grant_rom, bus.m2);
    end
    #2;
    poc_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (obs() !== 16'h0) begin
      n_fail++;
      $display("FAIL poc_async: got %b required 0", obs());
    end
`ifdef MCS4_SEQ_CYCLE_CNT_EN
    n_chk++;
    if (bus.cycle_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL poc_cnt: got %h required 0", bus.cycle_cnt);
    end
`endif
    @(posedge sysclk);
    #1;
    poc_n = 1'b1;
    for (int i = 0; i < CYC + 4; i++) begin
      tick();
      rand_io();
      n_chk++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL poc_restart p=%0d: got %b required %b", m_p, obs(), exp_vec());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_free_run();
    test_io_read();
    test_conflict();
    test_halt();
    test_random();
    test_poc_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
